// File: rtl/sha_mem_arbiter_pkg.sv
// Shared types, widths and the round-robin helper for the SHA engine memory arbiter.
package sha_pkg;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 32;
   localparam int MAX_REQ = 8;

   typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_e;

   // One-hot pick of the first set bit among the low n bits, searching upward from last+1 with wrap.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         last,
                                                 input int                 n);
      logic [MAX_REQ-1:0] pick;
      logic               found;
      logic [2:0]         idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         idx = 3'((int'(last) + k) % n);
         if (!found && (k <= n) && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/sha_mem_arbiter_rr_select.sv
// Combinational round-robin priority picker; also intended for the nonce dispatcher.
module rr_select
   import sha_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic [N-1:0]         pick
);

   logic [MAX_REQ-1:0] pickWide;
   logic               unusedPickHi;

   always_comb begin
      pickWide = rr_pick(MAX_REQ'(req), 3'(last), N);
   end

   assign pick         = pickWide[N-1:0];
   assign unusedPickHi = |pickWide;

endmodule

// File: rtl/sha_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port among NUM_REQ SHA engines,
// with registered read data returned to the engine that issued the read.
module sha_mem_arbiter
   import sha_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [DATA_W-1:0]         rd_data,
   output logic [NUM_REQ-1:0]        rd_valid,
   output logic                      mem_clk,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_write_data,
   input  logic [DATA_W-1:0]         mem_read_data,
   output logic                      busy
);

   localparam int LW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   arb_state_e         state_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic [LW-1:0]      owner_q;
   logic [LW-1:0]      last_q;
   logic [BW-1:0]      burst_q;
   logic [NUM_REQ-1:0] rdPend_q;
   logic [NUM_REQ-1:0] rdValid_q;
   logic [DATA_W-1:0]  rdData_q;
   logic [ADDR_W-1:0]  addrHold_q;
   logic [DATA_W-1:0]  wdataHold_q;

   logic [LW-1:0]      pickLast;
   logic [NUM_REQ-1:0] pick;
   logic [LW-1:0]      pickIdx;
   logic               granted;
   logic               ownerReq;
   logic               ownerWe;
   logic [ADDR_W-1:0]  ownerAddr;
   logic [DATA_W-1:0]  ownerWdata;

   // In DRAIN the owner that just finished becomes the rotation origin in the same cycle.
   assign pickLast = (state_q == DRAIN) ? owner_q : last_q;

   rr_select #(.N(NUM_REQ)) u_rr_select (
      .req  (req),
      .last (pickLast),
      .pick (pick)
   );

   always_comb begin
      pickIdx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) pickIdx = LW'(i);
      end
   end

   always_comb begin
      ownerReq   = 1'b0;
      ownerWe    = 1'b0;
      ownerAddr  = '0;
      ownerWdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == LW'(i)) begin
            ownerReq   = req[i];
            ownerWe    = req_we[i];
            ownerAddr  = req_addr[ADDR_W*i +: ADDR_W];
            ownerWdata = req_wdata[DATA_W*i +: DATA_W];
         end
      end
   end

   assign granted        = |gnt_q;
   assign mem_clk        = clk;
   assign mem_we         = granted & ownerWe;
   assign mem_addr       = granted ? ownerAddr  : addrHold_q;
   assign mem_write_data = granted ? ownerWdata : wdataHold_q;
   assign gnt            = gnt_q;
   assign rd_valid       = rdValid_q;
   assign rd_data        = rdData_q;
   assign busy           = (state_q != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         last_q  <= LW'(NUM_REQ - 1);
         burst_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  gnt_q   <= pick;
                  owner_q <= pickIdx;
                  burst_q <= BW'(1);
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (!ownerReq) begin
                  gnt_q   <= '0;
                  state_q <= DRAIN;
               end else if (burst_q == BW'(MAX_BURST)) begin
                  // Forced hand-off only under contention; a lone requester keeps the port.
                  if (|(req & ~gnt_q)) begin
                     gnt_q   <= '0;
                     state_q <= DRAIN;
                  end
               end else begin
                  burst_q <= burst_q + 1'b1;
               end
            end
            DRAIN: begin
               last_q <= owner_q;
               if (|req) begin
                  gnt_q   <= pick;
                  owner_q <= pickIdx;
                  burst_q <= BW'(1);
                  state_q <= GRANT;
               end else begin
                  burst_q <= '0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A cycle where the owner has already dropped req is its release, not a read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdPend_q    <= '0;
         rdValid_q   <= '0;
         rdData_q    <= '0;
         addrHold_q  <= '0;
         wdataHold_q <= '0;
      end else begin
         rdPend_q  <= (granted && ownerReq && !ownerWe) ? gnt_q : '0;
         rdValid_q <= rdPend_q;
         if (|rdPend_q) rdData_q <= mem_read_data;
         if (granted) begin
            addrHold_q  <= ownerAddr;
            wdataHold_q <= ownerWdata;
         end
      end
   end

endmodule
